// File: rtl/uart_prog_loader_if.sv
// uart_prog_loader_if: instruction RAM write port driven by the program loader.
//   imem_we    : single-cycle write strobe
//   imem_addr  : word address of the write (ADDR_W bits)
//   imem_wdata : 32-bit word to write
// master = loader side (drives), slave = instruction RAM side (receives).
interface uart_prog_loader_if #(
    parameter int ADDR_W = 12
);
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        output imem_we,
        output imem_addr,
        output imem_wdata
    );

    modport slave (
        input imem_we,
        input imem_addr,
        input imem_wdata
    );
endinterface

// File: rtl/uart_prog_loader.sv
// uart_prog_loader: boot-time loader that receives a framed program image over
// an 8N1 UART line, assembles little-endian 32-bit words and writes them into
// the instruction RAM while holding the CPU in reset.
// Frame: 0xA5, N[7:0], N[15:8], then 4*N payload bytes (first byte -> [7:0]).
// Ports:
//   clck      : system clock, rising edge
//   rst_n     : synchronous active-low reset
//   rx        : asynchronous UART receive line, idle high
//   imem      : instruction RAM write port (master modport)
//   cpu_rst_n : active-low CPU reset, low while a load is in progress
//   busy      : high from header accept until load completes or errors
//   done      : high after a successful load, cleared by the next header
//   frame_err : sticky error flag, cleared by the next header
module uart_prog_loader #(
    parameter int CLKS_PER_BIT = 434,
    parameter int ADDR_W       = 12
) (
    input  logic               clck,
    input  logic               rst_n,
    input  logic               rx,
    uart_prog_loader_if.master imem,
    output logic               cpu_rst_n,
    output logic               busy,
    output logic               done,
    output logic               frame_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1   = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1   = CW'(CLKS_PER_BIT - 1);
    localparam logic [16:0]   MAX_WORDS = 17'(2 ** ADDR_W);
    localparam logic [7:0]    HDR_BYTE  = 8'hA5;

    typedef enum logic [1:0] {RX_IDLE, START, DATA, STOP} rx_state_e;
    typedef enum logic [2:0] {IDLE, CNT_LO, CNT_HI, LOAD, DONE, ERR} ld_state_e;

    // ---------------- RX front end ----------------
    logic            sync1_q, sync2_q, prev_q;
    rx_state_e       rx_state_q, rx_state_d;
    logic [CW-1:0]   clk_cnt_q, clk_cnt_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      rx_shift_q, rx_shift_d;
    logic            byte_valid, byte_err;

    always_ff @(posedge clck) begin
        if (!rst_n) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            prev_q     <= 1'b1;
            rx_state_q <= RX_IDLE;
            clk_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            rx_shift_q <= '0;
        end else begin
            sync1_q    <= rx;
            sync2_q    <= sync1_q;
            prev_q     <= sync2_q;
            rx_state_q <= rx_state_d;
            clk_cnt_q  <= clk_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_shift_q <= rx_shift_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        clk_cnt_d  = clk_cnt_q + CW'(1);
        bit_cnt_d  = bit_cnt_q;
        rx_shift_d = rx_shift_q;
        byte_valid = 1'b0;
        byte_err   = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                clk_cnt_d = '0;
                if (prev_q && !sync2_q) rx_state_d = START;
            end
            START: begin
                // Mid-start-bit check: a line already back high was a glitch.
                if (clk_cnt_q == HALF_M1) begin
                    clk_cnt_d  = '0;
                    bit_cnt_d  = '0;
                    rx_state_d = sync2_q ? RX_IDLE : DATA;
                end
            end
            DATA: begin
                if (clk_cnt_q == FULL_M1) begin
                    clk_cnt_d  = '0;
                    rx_shift_d = {sync2_q, rx_shift_q[7:1]};
                    bit_cnt_d  = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) rx_state_d = STOP;
                end
            end
            STOP: begin
                if (clk_cnt_q == FULL_M1) begin
                    clk_cnt_d  = '0;
                    rx_state_d = RX_IDLE;
                    if (sync2_q) byte_valid = 1'b1;
                    else         byte_err   = 1'b1;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // ---------------- Loader ----------------
    ld_state_e         ld_state_q, ld_state_d;
    logic [15:0]       n_q, n_d, n_new;
    logic [15:0]       written_q, written_d;
    logic [1:0]        bidx_q, bidx_d;
    logic [31:0]       word_q, word_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              cpu_rst_n_q, cpu_rst_n_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              ferr_q, ferr_d;

    always_ff @(posedge clck) begin
        if (!rst_n) begin
            ld_state_q  <= IDLE;
            n_q         <= '0;
            written_q   <= '0;
            bidx_q      <= '0;
            word_q      <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_rst_n_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ferr_q      <= 1'b0;
        end else begin
            ld_state_q  <= ld_state_d;
            n_q         <= n_d;
            written_q   <= written_d;
            bidx_q      <= bidx_d;
            word_q      <= word_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cpu_rst_n_q <= cpu_rst_n_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            ferr_q      <= ferr_d;
        end
    end

    always_comb begin
        ld_state_d  = ld_state_q;
        n_d         = n_q;
        n_new       = {rx_shift_q, n_q[7:0]};
        written_d   = written_q;
        bidx_d      = bidx_q;
        word_d      = word_q;
        we_d        = 1'b0;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cpu_rst_n_d = cpu_rst_n_q;
        busy_d      = busy_q;
        done_d      = done_q;
        ferr_d      = ferr_q;
        case (ld_state_q)
            IDLE, DONE, ERR: begin
                if (byte_valid && rx_shift_q == HDR_BYTE) begin
                    ld_state_d  = CNT_LO;
                    busy_d      = 1'b1;
                    cpu_rst_n_d = 1'b0;
                    done_d      = 1'b0;
                    ferr_d      = 1'b0;
                    addr_d      = '0;
                    bidx_d      = '0;
                end
            end
            CNT_LO: begin
                if (byte_err) begin
                    ld_state_d = ERR;
                    busy_d     = 1'b0;
                    ferr_d     = 1'b1;
                end else if (byte_valid) begin
                    n_d[7:0]   = rx_shift_q;
                    ld_state_d = CNT_HI;
                end
            end
            CNT_HI: begin
                if (byte_err) begin
                    ld_state_d = ERR;
                    busy_d     = 1'b0;
                    ferr_d     = 1'b1;
                end else if (byte_valid) begin
                    n_d = n_new;
                    if (n_new == '0 || {1'b0, n_new} > MAX_WORDS) begin
                        ld_state_d = ERR;
                        busy_d     = 1'b0;
                        ferr_d     = 1'b1;
                    end else begin
                        ld_state_d = LOAD;
                        written_d  = '0;
                    end
                end
            end
            LOAD: begin
                // Strobe cycle: advance the address and finish after word N.
                if (we_q) begin
                    addr_d    = addr_q + ADDR_W'(1);
                    written_d = written_q + 16'd1;
                    if (written_q + 16'd1 == n_q) begin
                        ld_state_d  = DONE;
                        busy_d      = 1'b0;
                        done_d      = 1'b1;
                        cpu_rst_n_d = 1'b1;
                    end
                end
                if (byte_err) begin
                    ld_state_d = ERR;
                    busy_d     = 1'b0;
                    ferr_d     = 1'b1;
                end else if (byte_valid) begin
                    word_d = {rx_shift_q, word_q[31:8]};
                    bidx_d = bidx_q + 2'd1;
                    if (bidx_q == 2'd3) begin
                        we_d    = 1'b1;
                        wdata_d = {rx_shift_q, word_q[31:8]};
                    end
                end
            end
            default: ld_state_d = IDLE;
        endcase
    end

    assign imem.imem_we    = we_q;
    assign imem.imem_addr  = addr_q;
    assign imem.imem_wdata = wdata_q;
    assign cpu_rst_n       = cpu_rst_n_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign frame_err       = ferr_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
module tb_uart_prog_loader;
    localparam int CPB = 4;
    localparam int AW  = 12;

    logic clck = 1'b0;
    logic rst_n;
    logic rx;
    logic cpu_rst_n, busy, done, frame_err;

    uart_prog_loader_if #(.ADDR_W(AW)) imem_bus ();

    uart_prog_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW)) dut (
        .clck      (clck),
        .rst_n     (rst_n),
        .rx        (rx),
        .imem      (imem_bus.master),
        .cpu_rst_n (cpu_rst_n),
        .busy      (busy),
        .done      (done),
        .frame_err (frame_err)
    );

    always #5 clck = ~clck;

    int total = 0;
    int bad   = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // ---------------- byte-level reference model ----------------
    typedef struct {
        int unsigned addr;
        logic [31:0] data;
        bit          last;
    } wr_t;

    wr_t         exp_q[$];
    int unsigned log_addr[$];
    logic [31:0] log_data[$];

    int          m_phase;      // 0 waiting header, 1 count lo, 2 count hi, 3 payload
    int unsigned m_n, m_words, m_k, m_addr;
    logic [31:0] m_part;
    bit          m_busy, m_done, m_ferr, m_cpu;
    bit          post_chk = 1'b0;
    bit          prev_we  = 1'b0;

    task automatic model_reset();
        m_phase = 0; m_n = 0; m_words = 0; m_k = 0; m_addr = 0; m_part = '0;
        m_busy = 0; m_done = 0; m_ferr = 0; m_cpu = 1;
        exp_q.delete();
        post_chk = 1'b0;
    endtask

    function automatic void model_byte(logic [7:0] b, bit good);
        if (!good) begin
            if (m_phase != 0) begin
                m_phase = 0; m_busy = 0; m_ferr = 1;
            end
            return;
        end
        case (m_phase)
            0: if (b == 8'hA5) begin
                m_phase = 1; m_busy = 1; m_cpu = 0; m_done = 0; m_ferr = 0;
                m_addr = 0; m_k = 0; m_part = '0; m_words = 0;
            end
            1: begin m_n = b; m_phase = 2; end
            2: begin
                m_n = m_n + 256 * b;
                if (m_n == 0 || m_n > (1 << AW)) begin
                    m_phase = 0; m_busy = 0; m_ferr = 1;
                end else m_phase = 3;
            end
            default: begin
                m_part = m_part | (32'(b) << (8 * m_k));
                m_k++;
                if (m_k == 4) begin
                    exp_q.push_back('{addr: m_addr % (1 << AW), data: m_part,
                                      last: (m_words + 1 == m_n)});
                    m_addr++; m_words++; m_k = 0; m_part = '0;
                    if (m_words == m_n) begin
                        m_phase = 0; m_busy = 0; m_done = 1; m_cpu = 1;
                    end
                end
            end
        endcase
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clck) begin
        if (post_chk) begin
            chk("after_last_done", done, 1);
            chk("after_last_busy", busy, 0);
            chk("after_last_cpu_rst_n", cpu_rst_n, 1);
            post_chk = 1'b0;
        end
        if (busy) chk("cpu_held_while_busy", cpu_rst_n, 0);
        if (imem_bus.imem_we === 1'b1) begin
            chk("we_single_cycle", prev_we, 0);
            log_addr.push_back(imem_bus.imem_addr);
            log_data.push_back(imem_bus.imem_wdata);
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_write: got addr=%0h data=%0h expected no write",
                         imem_bus.imem_addr, imem_bus.imem_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("write_addr", imem_bus.imem_addr, e.addr);
                chk("write_data", imem_bus.imem_wdata, e.data);
                if (e.last) post_chk = 1'b1;
            end
        end
        prev_we = imem_bus.imem_we;
    end

    // ---------------- stimulus ----------------
    logic [7:0] seq[$];

    task automatic send_byte(input logic [7:0] b, input bit good);
        model_byte(b, good);
        rx = 1'b0;
        repeat (CPB) @(negedge clck);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clck);
        end
        rx = good;
        repeat (CPB) @(negedge clck);
        rx = 1'b1;
        if (!good) repeat (CPB) @(negedge clck);
        repeat ($urandom_range(0, 2)) @(negedge clck);
    endtask

    task automatic send_seq();
        foreach (seq[i]) send_byte(seq[i], 1'b1);
    endtask

    task automatic check_status(string tag);
        repeat (2 * CPB) @(negedge clck);
        #1;
        chk({tag, "_busy"}, busy, m_busy);
        chk({tag, "_done"}, done, m_done);
        chk({tag, "_frame_err"}, frame_err, m_ferr);
        chk({tag, "_cpu_rst_n"}, cpu_rst_n, m_cpu);
        chk({tag, "_pending_writes"}, exp_q.size(), 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got no finish expected finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rx    = 1'b1;
        rst_n = 1'b0;
        model_reset();
        repeat (5) @(negedge clck);
        rst_n = 1'b1;
        repeat (100) @(negedge clck);
        #1;
        chk("reset_cpu_rst_n", cpu_rst_n, 1);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_frame_err", frame_err, 0);
        chk("reset_addr", imem_bus.imem_addr, 0);
        chk("reset_wdata", imem_bus.imem_wdata, 0);
        chk("reset_no_writes", log_data.size(), 0);

        // Two-word image
        log_addr.delete(); log_data.delete();
        seq = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'hB7, 8'h02, 8'h00, 8'h00};
        send_seq();
        check_status("two_word");
        chk("two_word_count", log_data.size(), 2);
        if (log_data.size() == 2) begin
            chk("two_word_a0", log_addr[0], 0);
            chk("two_word_d0", log_data[0], 32'h00100513);
            chk("two_word_a1", log_addr[1], 1);
            chk("two_word_d1", log_data[1], 32'h000002B7);
        end
        chk("two_word_done_lit", done, 1);

        // Leading junk before header
        log_addr.delete(); log_data.delete();
        seq = '{8'h00, 8'h41, 8'hA5, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        send_seq();
        check_status("junk_then_load");
        chk("deadbeef_count", log_data.size(), 1);
        if (log_data.size() == 1) begin
            chk("deadbeef_addr", log_addr[0], 0);
            chk("deadbeef_data", log_data[0], 32'hDEADBEEF);
        end

        // Framing error inside a load, then recovery
        log_addr.delete(); log_data.delete();
        seq = '{8'hA5, 8'h03, 8'h00};
        send_seq();
        send_byte(8'h3C, 1'b0);
        check_status("stop_err");
        chk("stop_err_flag_lit", frame_err, 1);
        chk("stop_err_cpu_lit", cpu_rst_n, 0);
        chk("stop_err_no_write", log_data.size(), 0);
        seq = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
        send_seq();
        check_status("recover");
        chk("recover_ferr_lit", frame_err, 0);
        chk("recover_done_lit", done, 1);
        if (log_data.size() == 1) chk("recover_data", log_data[0], 32'h44332211);

        // Invalid counts
        log_addr.delete(); log_data.delete();
        seq = '{8'hA5, 8'h00, 8'h00};
        send_seq();
        check_status("n_zero");
        chk("n_zero_ferr_lit", frame_err, 1);
        seq = '{8'hA5, 8'h01, 8'h10};
        send_seq();
        check_status("n_4097");
        chk("n_4097_ferr_lit", frame_err, 1);
        chk("bad_n_no_write", log_data.size(), 0);

        // Glitch on idle line
        @(negedge clck) rx = 1'b0;
        @(negedge clck) rx = 1'b1;
        repeat (3 * CPB) @(negedge clck);
        check_status("glitch");
        chk("glitch_no_write", log_data.size(), 0);

        // Reset mid-load after 2 of 4 words
        seq = '{8'hA5, 8'h04, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        send_seq();
        repeat (2 * CPB) @(negedge clck);
        chk("midload_writes", log_data.size(), 2);
        chk("midload_busy", busy, 1);
        rst_n = 1'b0;
        model_reset();
        @(negedge clck);
        rst_n = 1'b1;
        #1;
        chk("midrst_cpu_rst_n", cpu_rst_n, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_frame_err", frame_err, 0);
        chk("midrst_we", imem_bus.imem_we, 0);
        chk("midrst_addr", imem_bus.imem_addr, 0);
        chk("midrst_wdata", imem_bus.imem_wdata, 0);
        log_addr.delete(); log_data.delete();
        seq = '{8'hA5, 8'h02, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h10, 8'h20, 8'h30, 8'h40};
        send_seq();
        check_status("after_rst");
        if (log_addr.size() == 2) begin
            chk("after_rst_a0", log_addr[0], 0);
            chk("after_rst_d1", log_data[1], 32'h40302010);
        end

        // Randomized loads with junk and occasional framing errors
        for (int it = 0; it < 12; it++) begin
            int unsigned nwords, err_at;
            logic [7:0]  b;
            repeat ($urandom_range(0, 2)) begin
                b = 8'($urandom);
                if (b == 8'hA5) b = 8'h5A;
                send_byte(b, $urandom_range(0, 3) != 0);
            end
            nwords = $urandom_range(1, 5);
            err_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 4 * nwords + 1) : 9999;
            seq = '{8'hA5, 8'(nwords), 8'h00};
            send_seq();
            for (int unsigned k = 0; k < 4 * nwords; k++) begin
                b = 8'($urandom);
                if (k == err_at) begin
                    send_byte(b, 1'b0);
                    break;
                end
                send_byte(b, 1'b1);
            end
            check_status("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_prog_loader.md
Name: uart_prog_loader

Overview:
- Boot-time program loader that sits directly upstream of the CPU's instruction RAM.
- Receives a framed program image over a UART RX line (8N1) and assembles little-endian 32-bit words.
- Writes each word into the instruction RAM write port and holds the CPU in reset for the duration of a load.
- Releases the CPU reset when the last word has been written, so the CPU restarts from PC 0 on the new image.

Parameters:
- CLKS_PER_BIT, 434, clck cycles per UART bit (50 MHz / 115200); must be >= 4.
- ADDR_W, 12, instruction RAM address width (4096 words).

Ports:
- clck  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- rx  input  1  asynchronous UART receive line; idle high.
- imem_we  output  1  single-cycle write strobe to the instruction RAM.
- imem_addr  output  ADDR_W  word address for the write.
- imem_wdata  output  32  word to write.
- cpu_rst_n  output  1  active-low reset to the CPU; low while a load is in progress.
- busy  output  1  high from header accept until the load completes or errors.
- done  output  1  high after a successful load; cleared by the next header.
- frame_err  output  1  sticky error flag; cleared by the next header.

Behaviour:
- Reset values:
  - imem_we=0, imem_addr=0, imem_wdata=0.
  - cpu_rst_n=1, so the preloaded program runs.
  - busy=0, done=0, frame_err=0.
  - Loader FSM=IDLE, RX FSM=RX_IDLE.
- A reset asserted mid-load abandons the load and returns to these values. The partially written RAM is not restored.
- RX front end:
  - rx passes through a 2-flop synchronizer, initialised to 1.
  - A start bit is a synchronized high-to-low transition seen in RX_IDLE.
  - The line is sampled at CLKS_PER_BIT/2 into the start bit. If it is high again, the edge is discarded as a glitch and the FSM returns to RX_IDLE.
  - 8 data bits are then sampled, LSB first, each CLKS_PER_BIT later, followed by one stop bit.
  - Stop bit = 1: byte_valid pulses for 1 cycle, with the byte.
  - Stop bit = 0: byte_err pulses for 1 cycle and no byte is delivered.
  - RX FSM states: RX_IDLE, START, DATA, STOP.
- Loader FSM states: IDLE, CNT_LO, CNT_HI, LOAD, DONE, ERR.
  - IDLE/DONE/ERR:
    - A byte 0xA5 moves to CNT_LO; set busy=1, cpu_rst_n=0, done=0, frame_err=0, imem_addr=0, byte index=0.
    - Any other byte is ignored.
    - byte_err is ignored in these states.
  - CNT_LO: the byte becomes word count N[7:0]; go to CNT_HI.
  - CNT_HI: the byte becomes N[15:8].
    - N==0 or N>2**ADDR_W: go to ERR.
    - Otherwise go to LOAD.
  - LOAD:
    - Bytes fill a shift register, little-endian (first byte -> [7:0]).
    - On the 4th byte of a word, the cycle after that byte_valid: imem_wdata=assembled word, imem_we=1 for exactly 1 cycle, at the current imem_addr.
    - imem_addr increments the cycle after the strobe, wrapping modulo 2**ADDR_W.
    - After word N is written, go to DONE.
    - 0xA5 inside LOAD is data, not a header.
  - DONE: busy=0, done=1, cpu_rst_n=1 on the cycle after the final imem_we. The CPU comes out of reset no earlier than the cycle after the last write.
  - ERR:
    - Entered from any of CNT_LO, CNT_HI or LOAD on byte_err, or on an invalid N.
    - busy=0, frame_err=1, cpu_rst_n stays 0 until a new 0xA5 header arrives.
- Throughput: at most one byte per 10*CLKS_PER_BIT cycles, so there is no back-pressure and no buffering beyond one word.
- imem_we is never asserted outside LOAD.
- A simultaneous byte_valid and final-word write cannot occur, by construction.

Test Plan:
- CLKS_PER_BIT=4; after reset with rx idle high for 100 cycles -> cpu_rst_n=1, busy=0, done=0, frame_err=0, imem_we never asserted.
- Send A5 02 00 13 05 10 00 B7 02 00 00:
  - Two imem_we pulses: addr 0 with data 0x00100513, then addr 1 with data 0x000002B7.
  - cpu_rst_n=0 from the header until the cycle after the 2nd write, then 1.
  - done=1, busy=0.
- Send 0x00, 0x41, then A5 01 00 EF BE AD DE -> leading bytes ignored; single write at addr 0 with data 0xDEADBEEF; done=1.
- Header A5 03 00 followed by a byte with stop bit forced 0:
  - frame_err=1, cpu_rst_n stays 0, busy=0, no further writes.
  - A following valid A5 01 00 + 4 bytes clears frame_err and completes the load.
- A5 00 00 -> ERR immediately, no imem_we.
- A5 01 10 (N=4097) -> ERR, no imem_we.
- rst_n low for 1 cycle after 2 of 4 words in LOAD:
  - All outputs return to reset values (cpu_rst_n=1).
  - A subsequent full load restarts at addr 0.
- A 1-cycle low glitch on rx (shorter than CLKS_PER_BIT/2) -> no byte_valid, FSM state unchanged.
